// File: rtl/spi_pkg.sv
// Shared constants, frame layout and FSM state encoding for the SPI register-access master.
package spi_pkg;

    localparam int OP_W    = 3;
    localparam int ADR_W   = 10;
    localparam int DAT_W   = 16;
    localparam int FRAME_W = OP_W + ADR_W + 3 + DAT_W;

    localparam logic [OP_W-1:0] OP_READ   = 3'b100;
    localparam logic [OP_W-1:0] OP_WRITE  = 3'b110;
    localparam logic [2:0]      XFER_NONE = 3'b000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT,
        ST_HOLD,
        ST_GAP
    } spi_state_e;

    // Reads carry an all-zero data field; the slave ignores it.
    function automatic logic [FRAME_W-1:0] build_frame(input logic             we,
                                                       input logic [ADR_W-1:0] adr,
                                                       input logic [DAT_W-1:0] dat);
        logic [DAT_W-1:0] payload;
        payload = we ? dat : {DAT_W{1'b0}};
        return {(we ? OP_WRITE : OP_READ), adr, XFER_NONE, payload};
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK divider: runs while enabled, ticks at the end of every CLK_DIV-cycle half-period
// and toggles sclk on ticks where toggling is allowed.
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic tog_en,
    output logic tick,
    output logic rise,
    output logic fall,
    output logic sclk
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] cnt_q;
    logic             sclk_q;

    assign tick = en && (cnt_q == DIV_LAST);
    assign rise = tick && tog_en && !sclk_q;
    assign fall = tick && tog_en && sclk_q;
    assign sclk = sclk_q;

    // Divider count and SCLK level; both park at zero whenever the divider is disabled.
    always_ff @(posedge clk_i) begin
        if (rst_i || !en) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q <= tick ? '0 : cnt_q + DIV_W'(1);
            if (tick && tog_en) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_master.sv
// SPI master (CPOL=0, CPHA=1) issuing one 32-bit register read/write frame per command.
//
// state | meaning
// IDLE  | cs high, ready for a command
// SETUP | cs low, sclk low, one half-period before the first rising edge
// SHIFT | 64 half-periods; mosi updates on rises, miso captured on falls 17..32
// HOLD  | sclk low, mosi held at bit 0 so the slave commits a write
// GAP   | cs high for CS_GAP cycles; done and read data on the first cycle
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [9:0]  addr_i,
    input  logic [15:0] wdata_i,
    output logic        ready_o,
    output logic        done_o,
    output logic [15:0] rdata_o,
    output logic        sclk_o,
    output logic        mosi_o,
    output logic        cs_o,
    input  logic        miso_i
);
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [5:0]       HP_LAST  = 6'd63;

    spi_state_e         state_q, state_d;
    logic [5:0]         hp_q;
    logic [GAP_W-1:0]   gap_q;
    logic [FRAME_W-1:0] shreg_q;
    logic [DAT_W-1:0]   rx_q;
    logic [DAT_W-1:0]   rdata_q;
    logic               rd_q;
    logic               mosi_q;
    logic               accept;
    logic               gen_en;
    logic               tog_en;
    logic               tick;
    logic               rise;
    logic               fall;

    assign accept = req_i && (state_q == ST_IDLE);
    assign gen_en = (state_q == ST_SETUP) || (state_q == ST_SHIFT) || (state_q == ST_HOLD);
    // The last SHIFT half-period is already low, so its tick must not raise sclk again.
    assign tog_en = (state_q == ST_SETUP) || ((state_q == ST_SHIFT) && (hp_q != HP_LAST));

    assign ready_o = (state_q == ST_IDLE);
    assign cs_o    = !gen_en;
    assign done_o  = (state_q == ST_GAP) && (gap_q == '0);
    assign rdata_o = rdata_q;
    assign mosi_o  = mosi_q;

    spi_sclk_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_sclk_gen (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en     (gen_en),
        .tog_en (tog_en),
        .tick   (tick),
        .rise   (rise),
        .fall   (fall),
        .sclk   (sclk_o)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: every timed phase advances on a divider tick or the gap count.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: if (tick) state_d = ST_SHIFT;
            ST_SHIFT: if (tick && (hp_q == HP_LAST)) state_d = ST_HOLD;
            ST_HOLD:  if (tick) state_d = ST_GAP;
            ST_GAP:   if (gap_q == GAP_LAST) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Half-period and gap counters, both cleared outside their own state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hp_q  <= '0;
            gap_q <= '0;
        end else begin
            if (state_q != ST_SHIFT) begin
                hp_q <= '0;
            end else if (tick) begin
                hp_q <= hp_q + 6'd1;
            end
            gap_q <= (state_q == ST_GAP) ? gap_q + GAP_W'(1) : '0;
        end
    end

    // Frame load on accept, MSB-first shift-out on rises, miso capture on the data-phase falls.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q <= '0;
            rd_q    <= 1'b0;
            mosi_q  <= 1'b0;
            rx_q    <= '0;
        end else begin
            if (accept) begin
                shreg_q <= build_frame(we_i, addr_i, wdata_i);
                rd_q    <= !we_i;
                mosi_q  <= 1'b0;
            end else if (rise) begin
                mosi_q  <= shreg_q[FRAME_W-1];
                shreg_q <= {shreg_q[FRAME_W-2:0], 1'b0};
            end
            // hp_q >= 32 marks falling edges 17..32, the slave's data phase.
            if (fall && hp_q[5]) begin
                rx_q <= {rx_q[DAT_W-2:0], miso_i};
            end
        end
    end

    // Read data becomes visible on the first GAP cycle, alongside done_o.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if ((state_q == ST_HOLD) && tick && rd_q) begin
            rdata_q <= rx_q;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural register-access SPI slave.
module tb_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req, we, sel, miso;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic        req1, req2;
    logic        ready1, done1, sclk1, mosi1, cs1;
    logic        ready2, done2, sclk2, mosi2, cs2;
    logic [15:0] rdata1, rdata2;

    assign req1 = req && !sel;
    assign req2 = req && sel;

    spi_master #(.CLK_DIV(4), .CS_GAP(8)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready1), .done_o(done1), .rdata_o(rdata1), .sclk_o(sclk1), .mosi_o(mosi1),
        .cs_o(cs1), .miso_i(miso)
    );

    spi_master #(.CLK_DIV(2), .CS_GAP(8)) dut2 (
        .clk_i(clk), .rst_i(rst), .req_i(req2), .we_i(we), .addr_i(addr), .wdata_i(wdata),
        .ready_o(ready2), .done_o(done2), .rdata_o(rdata2), .sclk_o(sclk2), .mosi_o(mosi2),
        .cs_o(cs2), .miso_i(miso)
    );

    logic        s_ready, s_done, s_sclk, s_mosi, s_cs;
    logic [15:0] s_rdata;
    assign s_ready = sel ? ready2 : ready1;
    assign s_done  = sel ? done2  : done1;
    assign s_sclk  = sel ? sclk2  : sclk1;
    assign s_mosi  = sel ? mosi2  : mosi1;
    assign s_cs    = sel ? cs2    : cs1;
    assign s_rdata = sel ? rdata2 : rdata1;

    // Slave model, sampled on the falling clk edge where master outputs are stable.
    logic        sclk_prev = 1'b0;
    int          sl_rises = 0;
    int          sl_falls = 0;
    int          sl_frames = 0;
    logic [31:0] sl_sh = '0;
    logic [31:0] last_frame = '0;
    logic        sl_rd = 1'b0;
    logic        sl_wr = 1'b0;
    logic [9:0]  sl_adr = '0;
    logic [15:0] sl_word = '0;
    logic [15:0] sl_regs [0:1023];
    logic        ld_en;
    logic [9:0]  ld_adr;
    logic [15:0] ld_dat;

    always @(negedge clk) begin
        sclk_prev <= s_sclk;
        if (ld_en) sl_regs[ld_adr] <= ld_dat;
        if (s_cs) begin
            sl_rises <= 0;
            sl_falls <= 0;
            miso     <= 1'b0;
            sl_rd    <= 1'b0;
            sl_wr    <= 1'b0;
        end else begin
            if (s_sclk && !sclk_prev) begin
                sl_rises <= sl_rises + 1;
                if (sl_rd && sl_rises >= 16 && sl_rises < 32) miso <= sl_word[4'(31 - sl_rises)];
            end
            if (!s_sclk && sclk_prev) begin
                sl_sh    <= {sl_sh[30:0], s_mosi};
                sl_falls <= sl_falls + 1;
                if (sl_falls == 15) begin
                    sl_rd   <= (sl_sh[14:12] == 3'b100);
                    sl_wr   <= (sl_sh[14:12] == 3'b110);
                    sl_adr  <= sl_sh[11:2];
                    sl_word <= sl_regs[sl_sh[11:2]];
                end
                if (sl_falls == 31) begin
                    last_frame <= {sl_sh[30:0], s_mosi};
                    sl_frames  <= sl_frames + 1;
                    if (sl_wr) sl_regs[sl_adr] <= {sl_sh[14:0], s_mosi};
                end
            end
        end
    end

    int total = 0;
    int bad = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [9:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_adr = a; ld_dat = d;
        step();
        ld_en = 1'b0;
    endtask

    // Issues one command and stops on the done_o cycle (n_done = -1 if it never comes).
    task automatic send(input logic w, input logic [9:0] a, input logic [15:0] d,
                        output int n_done, output int low, output int rises,
                        output int r1, output int r2, output logic rdy_n1, output logic cs_n1);
        int   guard;
        logic prev;
        guard = 0;
        while (!s_ready && guard < 2000) begin
            step();
            guard++;
        end
        we = w; addr = a; wdata = d; req = 1'b1;
        step();
        req = 1'b0;
        rdy_n1 = s_ready; cs_n1 = s_cs;
        n_done = -1; low = 0; rises = 0; r1 = -1; r2 = -1; prev = 1'b0;
        for (int n = 1; n < 2000; n++) begin
            if (s_sclk && !prev) begin
                rises++;
                if (rises == 1) r1 = n;
                if (rises == 2) r2 = n;
            end
            prev = s_sclk;
            if (s_done) begin
                n_done = n;
                break;
            end
            if (!s_cs) low++;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b0;
        repeat (3) step();
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        total++; if (s_cs !== 1'b1) begin bad++; $display("FAIL reset_cs: got %b want 1", s_cs); end
        total++; if (s_sclk !== 1'b0) begin bad++; $display("FAIL reset_sclk: got %b want 0", s_sclk); end
        total++; if (s_mosi !== 1'b0) begin bad++; $display("FAIL reset_mosi: got %b want 0", s_mosi); end
        total++; if (s_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", s_done); end
        total++; if (s_rdata !== 16'h0000) begin bad++; $display("FAIL reset_rdata: got %h want 0000", s_rdata); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_write();
        int n_done, low, rises, r1, r2, k;
        logic rdy_n1, cs_n1;
        send(1'b1, 10'h2A5, 16'hBEEF, n_done, low, rises, r1, r2, rdy_n1, cs_n1);
        total++; if (rdy_n1 !== 1'b0) begin bad++; $display("FAIL wr_ready_drop: got %b want 0", rdy_n1); end
        total++; if (cs_n1 !== 1'b0) begin bad++; $display("FAIL wr_cs_after_accept: got %b want 0", cs_n1); end
        total++; if (n_done != 265) begin bad++; $display("FAIL wr_done_latency: got %0d want 265", n_done); end
        total++; if (low != 264) begin bad++; $display("FAIL wr_cs_low: got %0d want 264", low); end
        total++; if (rises != 32) begin bad++; $display("FAIL wr_sclk_rises: got %0d want 32", rises); end
        total++; if (r1 != 5) begin bad++; $display("FAIL wr_first_rise: got %0d want 5", r1); end
        total++; if (r2 - r1 != 8) begin bad++; $display("FAIL wr_sclk_period: got %0d want 8", r2 - r1); end
        total++; if (s_cs !== 1'b1) begin bad++; $display("FAIL wr_cs_at_done: got %b want 1", s_cs); end
        total++; if (last_frame !== 32'hD528BEEF) begin bad++; $display("FAIL wr_frame: got %h want D528BEEF", last_frame); end
        total++; if (sl_regs[10'h2A5] !== 16'hBEEF) begin bad++; $display("FAIL wr_commit: got %h want BEEF", sl_regs[10'h2A5]); end
        step();
        total++; if (s_done !== 1'b0) begin bad++; $display("FAIL wr_done_width: got %b want 0", s_done); end
        k = 1;
        while (!s_ready && k < 100) begin
            step();
            k++;
        end
        total++; if (k != 8) begin bad++; $display("FAIL wr_done_to_ready: got %0d want 8", k); end
    endtask

    task automatic test_read();
        int n_done, low, rises, r1, r2;
        logic rdy_n1, cs_n1;
        load(10'h013, 16'h1234);
        send(1'b0, 10'h013, 16'hFFFF, n_done, low, rises, r1, r2, rdy_n1, cs_n1);
        total++; if (n_done != 265) begin bad++; $display("FAIL rd_done_latency: got %0d want 265", n_done); end
        total++; if (s_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data_at_done: got %h want 1234", s_rdata); end
        total++; if (last_frame !== 32'h80980000) begin bad++; $display("FAIL rd_frame: got %h want 80980000", last_frame); end
        repeat (5) step();
        total++; if (s_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data_hold: got %h want 1234", s_rdata); end
        send(1'b1, 10'h044, 16'h0F0F, n_done, low, rises, r1, r2, rdy_n1, cs_n1);
        total++; if (s_rdata !== 16'h1234) begin bad++; $display("FAIL rd_data_after_write: got %h want 1234", s_rdata); end
        total++; if (sl_regs[10'h044] !== 16'h0F0F) begin bad++; $display("FAIL rd_follow_write: got %h want 0F0F", sl_regs[10'h044]); end
    endtask

    task automatic test_back_to_back();
        int f0, n, first_ready, hi, guard;
        guard = 0;
        while (!s_ready && guard < 2000) begin
            step();
            guard++;
        end
        f0 = sl_frames;
        we = 1'b1; addr = 10'h100; wdata = 16'h1111; req = 1'b1;
        step();
        addr = 10'h101; wdata = 16'h2222;
        first_ready = -1; hi = 0;
        for (n = 1; n < 2000; n++) begin
            if (s_ready) begin
                first_ready = n;
                break;
            end
            if (s_cs) hi++;
            step();
        end
        total++; if (first_ready != 273) begin bad++; $display("FAIL b2b_ready_time: got %0d want 273", first_ready); end
        // Eight GAP cycles; the IDLE cycle that accepts the second command follows.
        total++; if (hi != 8) begin bad++; $display("FAIL b2b_cs_gap: got %0d want 8", hi); end
        step();
        total++; if (s_ready !== 1'b0 || s_cs !== 1'b0) begin
            bad++; $display("FAIL b2b_second_accept: got ready=%b cs=%b want 0 0", s_ready, s_cs);
        end
        addr = 10'h1FF; wdata = 16'hDEAD;
        for (int k = 0; k < 150; k++) begin
            req = (k % 16 == 5);
            step();
        end
        req = 1'b0;
        guard = 0;
        while (!s_ready && guard < 2000) begin
            step();
            guard++;
        end
        repeat (20) step();
        total++; if (sl_frames - f0 != 2) begin bad++; $display("FAIL b2b_frames: got %0d want 2", sl_frames - f0); end
        total++; if (sl_regs[10'h100] !== 16'h1111 || sl_regs[10'h101] !== 16'h2222) begin
            bad++; $display("FAIL b2b_data: got %h %h want 1111 2222", sl_regs[10'h100], sl_regs[10'h101]);
        end
        total++; if (sl_regs[10'h1FF] === 16'hDEAD) begin bad++; $display("FAIL b2b_ignored_req: got %h want not DEAD", sl_regs[10'h1FF]); end
    endtask

    task automatic test_reset_mid_frame();
        int f0, rises, dones, n_done, low, rs, r1, r2;
        logic prev, rdy_n1, cs_n1;
        load(10'h001, 16'h5555);
        while (!s_ready) step();
        f0 = sl_frames;
        we = 1'b1; addr = 10'h001; wdata = 16'hAAAA; req = 1'b1;
        step();
        req = 1'b0;
        rises = 0; prev = 1'b0;
        for (int n = 0; n < 2000 && rises < 20; n++) begin
            if (s_sclk && !prev) rises++;
            prev = s_sclk;
            if (rises < 20) step();
        end
        total++; if (rises != 20) begin bad++; $display("FAIL abort_reach_rise20: got %0d want 20", rises); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (s_cs !== 1'b1 || s_sclk !== 1'b0) begin
            bad++; $display("FAIL abort_lines: got cs=%b sclk=%b want 1 0", s_cs, s_sclk);
        end
        total++; if (s_ready !== 1'b1 || s_rdata !== 16'h0000) begin
            bad++; $display("FAIL abort_state: got ready=%b rdata=%h want 1 0000", s_ready, s_rdata);
        end
        dones = 0;
        repeat (300) begin
            if (s_done) dones++;
            step();
        end
        total++; if (dones != 0) begin bad++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        total++; if (sl_regs[10'h001] !== 16'h5555 || sl_frames != f0) begin
            bad++; $display("FAIL abort_no_commit: got %h frames=%0d want 5555 frames=%0d", sl_regs[10'h001], sl_frames, f0);
        end
        send(1'b0, 10'h001, 16'h0000, n_done, low, rs, r1, r2, rdy_n1, cs_n1);
        total++; if (n_done != 265 || s_rdata !== 16'h5555) begin
            bad++; $display("FAIL abort_then_read: got n=%0d rdata=%h want 265 5555", n_done, s_rdata);
        end
    endtask

    task automatic test_clkdiv2();
        int n_done, low, rises, r1, r2;
        logic rdy_n1, cs_n1;
        sel = 1'b1;
        step();
        load(10'h3C2, 16'hA5C3);
        send(1'b0, 10'h3C2, 16'h0000, n_done, low, rises, r1, r2, rdy_n1, cs_n1);
        total++; if (r2 - r1 != 4) begin bad++; $display("FAIL div2_sclk_period: got %0d want 4", r2 - r1); end
        total++; if (r1 != 3) begin bad++; $display("FAIL div2_first_rise: got %0d want 3", r1); end
        total++; if (low != 132) begin bad++; $display("FAIL div2_cs_low: got %0d want 132", low); end
        total++; if (n_done != 133) begin bad++; $display("FAIL div2_done_latency: got %0d want 133", n_done); end
        total++; if (s_rdata !== 16'hA5C3) begin bad++; $display("FAIL div2_rdata: got %h want A5C3", s_rdata); end
        total++; if (last_frame !== 32'h9E100000) begin bad++; $display("FAIL div2_frame: got %h want 9E100000", last_frame); end
        sel = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; sel = 1'b0;
        ld_en = 1'b0; ld_adr = '0; ld_dat = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_frame();
        test_clkdiv2();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
